// File: rtl/sha1_padder_if.sv
// Word-stream handshake feeding the SHA-1 padder.
interface sha1_padder_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [2:0]  s_bytes;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_last, output s_bytes, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, input s_bytes, output s_ready);
endinterface

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a 32-bit word stream into padded 512-bit chunks,
// drives the core init/next handshake and captures the final digest.
module sha1_padder (
  input  logic         clk,
  input  logic         reset_n,
  sha1_padder_if.slave s,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_chunk,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic [159:0] core_digest,
  output logic [159:0] digest,
  output logic         done,
  output logic         busy
);
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CHUNK_WORDS = 16;
  localparam int unsigned CHUNK_W     = WORD_W * CHUNK_WORDS;
  localparam int unsigned LEN_W       = 64;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [2:0] {FILL, ISSUE, WAIT, PAD2, DONE} state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   chunk_buf [CHUNK_WORDS];
  logic [WORD_W-1:0]   buf_n     [CHUNK_WORDS];
  logic [IDX_W-1:0]    widx, widx_n;
  logic [LEN_W-1:0]    bitlen, bitlen_n;
  logic                final_q, final_n;
  logic                need_pad2, need_pad2_n;
  logic                pad_pending, pad_pending_n;
  logic                first, first_n;
  logic                busy_n, done_n;
  logic                load_chunk, digest_load;
  logic [CHUNK_W-1:0]  chunk_n;
  logic [2:0]          nb;
  logic [WORD_W-1:0]   keep_mask, pad_word;
  logic [6:0]          pad_pos;

  // Next-state, datapath updates and the Mealy core handshake pulses.
  always_comb begin
    state_n       = state;
    buf_n         = chunk_buf;
    widx_n        = widx;
    bitlen_n      = bitlen;
    final_n       = final_q;
    need_pad2_n   = need_pad2;
    pad_pending_n = pad_pending;
    first_n       = first;
    busy_n        = busy;
    done_n        = 1'b0;
    load_chunk    = 1'b0;
    digest_load   = 1'b0;
    core_init     = 1'b0;
    core_next     = 1'b0;
    chunk_n       = '0;

    // Valid byte count of a final word, saturated at a full word.
    nb = (s.s_bytes > 3'd4) ? 3'd4 : s.s_bytes;
    case (nb)
      3'd0:    keep_mask = 32'h0000_0000;
      3'd1:    keep_mask = 32'hFF00_0000;
      3'd2:    keep_mask = 32'hFFFF_0000;
      3'd3:    keep_mask = 32'hFFFF_FF00;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
    pad_word = (nb == 3'd4) ? 32'h0 : (32'h8000_0000 >> {nb[1:0], 3'b000});
    pad_pos  = 7'({widx, 2'b00}) + 7'(nb);

    case (state)
      FILL: begin
        if (s.s_valid && s.s_ready) begin
          busy_n = 1'b1;
          if (!s.s_last) begin
            buf_n[widx] = s.s_data;
            widx_n      = widx + 4'd1;
            bitlen_n    = bitlen + LEN_W'(WORD_W);
            if (widx == 4'd15) begin
              final_n    = 1'b0;
              load_chunk = 1'b1;
              state_n    = ISSUE;
            end
          end else begin
            bitlen_n = bitlen + LEN_W'({nb, 3'b000});
            for (int i = 0; i < CHUNK_WORDS; i++) begin
              if (4'(i) > widx) buf_n[i] = '0;
            end
            buf_n[widx] = (s.s_data & keep_mask) | pad_word;
            // A full final word pushes the 0x80 marker into the next word,
            // or into a second chunk when the word filled the chunk.
            if (nb == 3'd4) begin
              if (widx != 4'd15) buf_n[4'(widx + 4'd1)] = 32'h8000_0000;
              else               pad_pending_n = 1'b1;
            end
            if (pad_pos <= 7'd55) begin
              buf_n[14] = bitlen_n[63:32];
              buf_n[15] = bitlen_n[31:0];
              final_n   = 1'b1;
            end else begin
              final_n     = 1'b0;
              need_pad2_n = 1'b1;
            end
            load_chunk = 1'b1;
            state_n    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (core_ready) begin
          core_init = first;
          core_next = !first;
          first_n   = 1'b0;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        if (core_valid) begin
          if (final_q) begin
            digest_load = 1'b1;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = DONE;
          end else if (need_pad2) begin
            state_n = PAD2;
          end else begin
            for (int i = 0; i < CHUNK_WORDS; i++) buf_n[i] = '0;
            widx_n  = '0;
            state_n = FILL;
          end
        end
      end
      PAD2: begin
        for (int i = 0; i < CHUNK_WORDS; i++) buf_n[i] = '0;
        buf_n[0]      = pad_pending ? 32'h8000_0000 : 32'h0;
        buf_n[14]     = bitlen[63:32];
        buf_n[15]     = bitlen[31:0];
        final_n       = 1'b1;
        need_pad2_n   = 1'b0;
        pad_pending_n = 1'b0;
        load_chunk    = 1'b1;
        state_n       = ISSUE;
      end
      DONE: begin
        for (int i = 0; i < CHUNK_WORDS; i++) buf_n[i] = '0;
        bitlen_n = '0;
        widx_n   = '0;
        final_n  = 1'b0;
        first_n  = 1'b1;
        state_n  = FILL;
      end
      default: state_n = FILL;
    endcase

    for (int i = 0; i < CHUNK_WORDS; i++) begin
      chunk_n[CHUNK_W-1-WORD_W*i -: WORD_W] = buf_n[i];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      for (int i = 0; i < CHUNK_WORDS; i++) chunk_buf[i] <= '0;
      widx        <= '0;
      bitlen      <= '0;
      final_q     <= 1'b0;
      need_pad2   <= 1'b0;
      pad_pending <= 1'b0;
      first       <= 1'b1;
      s.s_ready   <= 1'b0;
      core_chunk  <= '0;
      digest      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      chunk_buf   <= buf_n;
      widx        <= widx_n;
      bitlen      <= bitlen_n;
      final_q     <= final_n;
      need_pad2   <= need_pad2_n;
      pad_pending <= pad_pending_n;
      first       <= first_n;
      s.s_ready   <= (state_n == FILL);
      if (load_chunk)  core_chunk <= chunk_n;
      if (digest_load) digest     <= core_digest;
      done        <= done_n;
      busy        <= busy_n;
    end
  end
endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder with a behavioural SHA-1 core model.
module tb_sha1_padder;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         core_init, core_next, core_ready, core_valid;
  logic [511:0] core_chunk;
  logic [159:0] core_digest, digest;
  logic         done, busy;

  sha1_padder_if bus ();

  sha1_padder dut (
    .clk(clk), .reset_n(reset_n), .s(bus),
    .core_init(core_init), .core_next(core_next), .core_chunk(core_chunk),
    .core_ready(core_ready), .core_valid(core_valid), .core_digest(core_digest),
    .digest(digest), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned pulse_cnt = 0;
  int unsigned last_acc_cyc = 0;

  logic [511:0] blk_q [$];
  logic         init_q [$];
  int unsigned  pcyc_q [$];
  logic [7:0]   msg_q [$];
  logic [511:0] ref_q [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // SHA-1 compression of one 512-bit block.
  function automatic logic [159:0] sha1_blk(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Core model: accepts a pulse while ready, computes for six cycles, then raises valid.
  logic         core_idle, hold_low;
  int unsigned  core_cnt;
  logic [159:0] h_q;
  logic [511:0] held_chunk;
  assign core_ready = core_idle && !hold_low;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_idle   <= 1'b1;
      core_valid  <= 1'b0;
      core_cnt    <= 0;
      h_q         <= '0;
      held_chunk  <= '0;
      core_digest <= '0;
    end else if (core_idle) begin
      if (core_ready && (core_init || core_next)) begin
        blk_q.push_back(core_chunk);
        init_q.push_back(core_init);
        h_q        <= sha1_blk(core_init ? IV : h_q, core_chunk);
        held_chunk <= core_chunk;
        core_idle  <= 1'b0;
        core_valid <= 1'b0;
        core_cnt   <= 6;
      end
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else begin
      check("chunk_stable", core_chunk, held_chunk);
      core_idle   <= 1'b1;
      core_valid  <= 1'b1;
      core_digest <= h_q;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (core_init || core_next) begin
      pulse_cnt++;
      pcyc_q.push_back(cyc);
      check("pulse_when_ready", 512'(core_ready), 512'(1));
      check("pulse_exclusive", 512'(core_init && core_next), 512'(0));
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    timeout_fail("watchdog");
  end

  typedef struct {
    int unsigned  n;
    int unsigned  pat;
    logic [2:0]   ovr;
    int unsigned  nchunks;
    logic [31:0]  w0;
    logic [31:0]  w15;
    bit           use_const;
    logic [159:0] dig;
    bit           gaps;
    bit           hold;
    bit           lat;
  } vec_t;

  vec_t vecs [10];

  task automatic build_msg(input int unsigned n, input int unsigned pat);
    string nist;
    nist = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      case (pat)
        0:       msg_q.push_back(8'(8'h61 + i));
        2:       msg_q.push_back(8'(nist[i]));
        default: msg_q.push_back(8'(i + 1));
      endcase
    end
  endtask

  // Reference SHA-1 padding of msg_q into ref_q.
  task automatic build_ref();
    logic [7:0]   p [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    p  = msg_q;
    bl = 64'(msg_q.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    ref_q.delete();
    for (int c = 0; c < p.size() / 64; c++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*c+j];
      ref_q.push_back(blk);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] sb, input bit gaps);
    int unsigned n;
    if (gaps) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_bytes = sb;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready) begin
      if (gaps) bus.s_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (n > 3000) timeout_fail("s_ready_wait");
    end
    bus.s_valid = 1'b1;
    @(negedge clk);
    last_acc_cyc = cyc;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
  endtask

  task automatic send_msg(input int unsigned first_w, input int unsigned cnt, input logic [2:0] ovr, input bit gaps);
    int unsigned n, nw, nbw;
    logic [31:0] d;
    logic        l;
    logic [2:0]  sb;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int unsigned w = first_w; w < first_w + cnt; w++) begin
      l   = (w == nw - 1);
      nbw = l ? n - 4 * w : 4;
      for (int unsigned b = 0; b < 4; b++) d[31-8*b -: 8] = (b < nbw) ? msg_q[4*w+b] : 8'hEE;
      sb  = !l ? 3'd1 : ((ovr != 3'd0) ? ovr : 3'(nbw));
      send_word(d, l, sb, gaps);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t         v;
    logic [159:0] exp_dig;
    logic [511:0] last_blk;
    int unsigned  d0, n, nw, p0;
    v = vecs[idx];
    build_msg(v.n, v.pat);
    build_ref();
    exp_dig = IV;
    foreach (ref_q[c]) exp_dig = sha1_blk(exp_dig, ref_q[c]);
    if (v.use_const) exp_dig = v.dig;
    nw = (v.n == 0) ? 1 : (v.n + 3) / 4;
    blk_q.delete();
    init_q.delete();
    pcyc_q.delete();
    d0 = done_cnt;
    fork
      send_msg(0, nw, v.ovr, v.gaps);
      begin
        if (v.hold) begin
          hold_low = 1'b1;
          n = 0;
          while (!(busy && !bus.s_ready)) begin
            @(negedge clk);
            n++;
            if (n > 4000) timeout_fail("hold_issue_wait");
          end
          p0 = pulse_cnt;
          repeat (10) @(negedge clk);
          check("hold_no_pulse", 512'(pulse_cnt), 512'(p0));
          hold_low = 1'b0;
        end
      end
    join
    n = 0;
    while (done_cnt == d0) begin
      @(negedge clk);
      n++;
      if (n > 4000) timeout_fail("done_wait");
    end
    repeat (3) @(negedge clk);
    check("n_chunks", 512'(blk_q.size()), 512'(v.nchunks));
    for (int c = 0; c < blk_q.size(); c++) begin
      if (c < ref_q.size()) check("chunk_content", blk_q[c], ref_q[c]);
      check("init_vs_next", 512'(init_q[c]), 512'(c == 0));
    end
    if (blk_q.size() > 0) begin
      last_blk = blk_q[blk_q.size()-1];
      check("last_word0", 512'(last_blk[511:480]), 512'(v.w0));
      check("last_word15", 512'(last_blk[31:0]), 512'(v.w15));
    end
    check("digest", 512'(digest), 512'(exp_dig));
    check("done_one_cycle", 512'(done_cnt - d0), 512'(1));
    check("busy_after_done", 512'(busy), 512'(0));
    if (v.lat && pcyc_q.size() > 0) check("issue_latency", 512'(pcyc_q[0]), 512'(last_acc_cyc));
  endtask

  initial begin
    vecs[0] = '{3,   0, 3'd0, 1, 32'h61626380, 32'h18,  1'b1,
                160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{0,   1, 3'd0, 1, 32'h80000000, 32'h0,   1'b1,
                160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{56,  2, 3'd0, 2, 32'h00000000, 32'h1C0, 1'b1,
                160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64,  3, 3'd0, 2, 32'h80000000, 32'h200, 1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{55,  3, 3'd0, 1, 32'h01020304, 32'h1B8, 1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7,   3, 3'd0, 1, 32'h01020304, 32'h38,  1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{120, 3, 3'd0, 3, 32'h00000000, 32'h3C0, 1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{128, 3, 3'd0, 3, 32'h80000000, 32'h400, 1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8,   3, 3'd7, 1, 32'h01020304, 32'h40,  1'b0, 160'h0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{70,  3, 3'd0, 2, 32'h41424344, 32'h230, 1'b0, 160'h0, 1'b1, 1'b1, 1'b0};

    reset_n     = 1'b0;
    hold_low    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.s_bytes = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 512'(bus.s_ready), 512'(0));
    check("rst_core_init", 512'(core_init), 512'(0));
    check("rst_core_next", 512'(core_next), 512'(0));
    check("rst_core_chunk", core_chunk, 512'(0));
    check("rst_digest", 512'(digest), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", 512'(bus.s_ready), 512'(1));

    for (int i = 0; i < 10; i++) run_vec(i);

    // Abort a two-chunk message while its first chunk is in the core.
    begin
      int unsigned n, d0;
      build_msg(100, 3);
      blk_q.delete();
      init_q.delete();
      pcyc_q.delete();
      d0 = done_cnt;
      send_msg(0, 16, 3'd0, 1'b0);
      n = 0;
      while (core_idle) begin
        @(negedge clk);
        n++;
        if (n > 100) timeout_fail("abort_pulse_wait");
      end
      check("abort_busy_before", 512'(busy), 512'(1));
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_no_done", 512'(done_cnt), 512'(d0));
      check("abort_busy", 512'(busy), 512'(0));
      check("abort_s_ready", 512'(bus.s_ready), 512'(0));
      check("abort_chunk", core_chunk, 512'(0));
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vec(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
